bin_bcd_display_ctrl: RTL and testbench
=======================================

Name: bin_bcd_display_ctrl

Overview:
Sequential binary-to-BCD converter and display controller for the board seven-segment readout.
- Captures a binary value from the processor (register/PC/ALU result) on a load strobe.
- Converts it with a double-dabble (shift/add-3) sequence, one bit per cycle.
- Publishes a stable, packed set of BCD digits. Each digit feeds one existing per-digit 7-segment decoder. Nibble 4'hF is a blank code (all segments off).

Parameters:
WIDTH, 16, bit width of binary input
DIGITS, 5, number of BCD digits produced; must satisfy 10^DIGITS > 2^WIDTH-1 (checked by elaboration-time assertion)

Ports:
clock  input  1  system clock, rising edge
reset_n  input  1  asynchronous active-low reset
valor  input  WIDTH  binary value to display, sampled on accepted load
load  input  1  start conversion; accepted only when ready=1
ready  output  1  controller idle, load will be accepted
busy  output  1  conversion in progress (SHIFT or COMMIT)
done  output  1  one-cycle pulse when digits updated
digits  output  DIGITS*4  packed BCD, digit 0 (units) in [3:0], most significant digit in top nibble

Behaviour:
- Reset (async assert, sync-safe deassert by board): state=IDLE, ready=1, busy=0, done=0, digits=all 4'h0, internal shift regs/counter cleared.
- States: IDLE, SHIFT, COMMIT.
- IDLE:
  - ready=1. On load=1: capture valor into bin_sr, clear bcd_sr, set cnt=WIDTH, go to SHIFT.
- SHIFT, one cycle per bit:
  - For each BCD nibble of bcd_sr: if nibble >= 5, add 3. This is combinational on the current register value.
  - Then shift {bcd_sr,bin_sr} left by 1. Decrement cnt.
  - When cnt reaches 1 before the shift, go to COMMIT next.
- COMMIT (one cycle):
  - digits <= bcd_sr, or the blanked form if the optional feature is enabled.
  - done=1 this cycle only. Go to IDLE.
- Latency: load sampled at edge N → done high during cycle N+WIDTH+1 → ready high again at N+WIDTH+2. Default WIDTH=16 gives 18 cycles load-to-ready.
- digits holds its previous value throughout a conversion (no flicker). It changes only at the COMMIT edge.
- load while busy=1 is ignored, not queued. valor changes after capture have no effect.
- load in the same cycle as COMMIT is ignored; ready=0 in COMMIT.
- Reset mid-conversion aborts immediately; digits returns to zeros.
- Arithmetic: add-3 is a 4-bit unsigned add, no carry out (nibble ≤ 9 before add, so result ≤ 12). bcd_sr width = DIGITS*4.
- ready = (state==IDLE); busy = ~ready.

Optional Feature:
Macro LEADING_ZERO_BLANK_EN.
- Defined: at COMMIT, every zero digit more significant than the highest non-zero digit is replaced by 4'hF (blank). Digit 0 is never blanked, so value 0 shows a single "0".
- Undefined: digits = raw BCD with leading zeros shown. No blanking logic is synthesized.

Decomposition:
- Shared package (display_pkg):
  - state enum (IDLE/SHIFT/COMMIT)
  - constant BLANK_DIGIT=4'hF
  - constant DIGIT_W=4
  - localparam function for counter width, $clog2(WIDTH+1)
- One natural sub-module: bcd_add3, a combinational nibble corrector (in 4, out 4: in>=5 ? in+3 : in). Generated DIGITS times.
- Segment decoding stays outside this block.

Test Plan:
- Reset then idle: reset_n low 3 cycles → digits=0x00000, ready=1, busy=0, done=0. Assert reset_n low asynchronously between edges → outputs clear without a clock edge.
- Load valor=16'd1234 → busy for 17 cycles, done pulses exactly once at cycle 17 after load. digits=20'h01234 (blank enabled: 20'hF1234). ready returns next cycle.
- Load valor=16'd65535 → digits=20'h65535. Load valor=0 → digits=20'h00000 (blank enabled: 20'hFFFF0).
- During conversion of 16'd42, pulse load with valor=16'd999 at cycles 3 and 17 (COMMIT) → both ignored. digits=20'h00042, and only one done pulse.
- Load 16'd500 to completion, then load 16'd7 and assert reset_n low at cycle 8 → digits=0, state IDLE. A fresh load of 16'd7 gives 20'h00007.
- Back-to-back: load asserted continuously with valor incrementing each cycle → a conversion starts every 18 cycles. Each committed digits matches the valor sampled at its accepted load.

Source files
------------

// File: rtl/display_pkg.sv
// ============================================================================
// Module      : display_pkg
// Description : Shared types and constants for the BCD display controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package display_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2
    } state_t;

    localparam int          DIGIT_W     = 4;
    localparam logic [3:0]  BLANK_DIGIT = 4'hF;

    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

    function automatic logic [63:0] pow10(input int n);
        logic [63:0] r;
        r = 64'd1;
        for (int i = 0; i < n; i++) begin
            r = r * 64'd10;
        end
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/bcd_add3.sv
// ============================================================================
// Module      : bcd_add3
// Description : Double-dabble nibble corrector: adds 3 when the digit is >= 5.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_add3 (
    input  logic [3:0] i_nib,
    output logic [3:0] o_nib
);

    assign o_nib = (i_nib >= 4'd5) ? (i_nib + 4'd3) : i_nib;

endmodule

`default_nettype wire

// File: rtl/bin_bcd_display_ctrl.sv
// ============================================================================
// Module      : bin_bcd_display_ctrl
// Description : Sequential binary-to-BCD converter (one bit per cycle) that
//               publishes stable packed digits for the 7-segment readout.
//               Optional macro LEADING_ZERO_BLANK_EN blanks leading zeros.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bin_bcd_display_ctrl
    import display_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [WIDTH-1:0]      valor,
    input  logic                  load,
    output logic                  ready,
    output logic                  busy,
    output logic                  done,
    output logic [DIGITS*4-1:0]   digits
);

    localparam int DW = DIGITS * DIGIT_W;
    localparam int CW = cnt_width(WIDTH);

    if (pow10(DIGITS) <= ((64'd1 << WIDTH) - 64'd1)) begin : g_digits_too_few
        $error("DIGITS too small to represent 2^WIDTH-1");
    end

    state_t           r_state;
    logic [WIDTH-1:0] r_bin;
    logic [DW-1:0]    r_bcd;
    logic [CW-1:0]    r_cnt;
    logic             r_done;
    logic [DW-1:0]    r_digits;

    logic [DW-1:0]    w_bcd_adj;
    logic [DW-1:0]    w_bcd_next;
    logic [DW-1:0]    w_digits_fmt;

    for (genvar g = 0; g < DIGITS; g++) begin : g_add3
        bcd_add3 u_add3 (
            .i_nib (r_bcd[g*DIGIT_W +: DIGIT_W]),
            .o_nib (w_bcd_adj[g*DIGIT_W +: DIGIT_W])
        );
    end

    assign w_bcd_next = {w_bcd_adj[DW-2:0], r_bin[WIDTH-1]};

`ifdef LEADING_ZERO_BLANK_EN
    always_comb begin
        logic w_lead;
        w_digits_fmt = w_bcd_next;
        w_lead       = 1'b1;
        // Scan from the top; digit 0 is never blanked so zero still shows "0".
        for (int i = DIGITS - 1; i > 0; i--) begin
            if (w_lead && (w_bcd_next[i*DIGIT_W +: DIGIT_W] == 4'd0)) begin
                w_digits_fmt[i*DIGIT_W +: DIGIT_W] = BLANK_DIGIT;
            end else begin
                w_lead = 1'b0;
            end
        end
    end
`else
    assign w_digits_fmt = w_bcd_next;
`endif

    // The last shift writes the display register directly, so digits and
    // done change together on entry to COMMIT.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= IDLE;
            r_bin    <= '0;
            r_bcd    <= '0;
            r_cnt    <= '0;
            r_done   <= 1'b0;
            r_digits <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (load) begin
                        r_bin   <= valor;
                        r_bcd   <= '0;
                        r_cnt   <= CW'(WIDTH);
                        r_state <= SHIFT;
                    end
                end
                SHIFT: begin
                    r_bcd <= w_bcd_next;
                    // Rotate the combined register; the bit leaving the top
                    // nibble is always zero given the DIGITS range check.
                    r_bin <= {r_bin[WIDTH-2:0], w_bcd_adj[DW-1]};
                    r_cnt <= r_cnt - CW'(1);
                    if (r_cnt == CW'(1)) begin
                        r_digits <= w_digits_fmt;
                        r_done   <= 1'b1;
                        r_state  <= COMMIT;
                    end
                end
                COMMIT: begin
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign ready  = (r_state == IDLE);
    assign busy   = ~ready;
    assign done   = r_done;
    assign digits = r_digits;

endmodule

`default_nettype wire

// File: tb/tb_bin_bcd_display_ctrl.sv
// ============================================================================
// Module      : tb_bin_bcd_display_ctrl
// Description : Self-checking bench for bin_bcd_display_ctrl (16-bit, 5 digits).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bin_bcd_display_ctrl;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [15:0] valor;
    logic        load;
    logic        ready;
    logic        busy;
    logic        done;
    logic [19:0] digits;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clock = ~clock;

    bin_bcd_display_ctrl #(
        .WIDTH  (16),
        .DIGITS (5)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .valor   (valor),
        .load    (load),
        .ready   (ready),
        .busy    (busy),
        .done    (done),
        .digits  (digits)
    );

    typedef struct {
        logic [15:0] val;
        logic [19:0] raw;
        logic [19:0] blank;
        int          inj_a;
        int          inj_b;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [19:0] expect_of(input vec_t v);
`ifdef LEADING_ZERO_BLANK_EN
        return v.blank;
`else
        return v.raw;
`endif
    endfunction

    // Reference by repeated division, independent of shift/add-3.
    function automatic logic [19:0] model(input int v);
        logic [19:0] r;
        int          x;
        bit          lead;
        x = v;
        for (int i = 0; i < 5; i++) begin
            r[i*4 +: 4] = 4'(x % 10);
            x = x / 10;
        end
        lead = 1'b1;
`ifdef LEADING_ZERO_BLANK_EN
        for (int i = 4; i > 0; i--) begin
            if (lead && r[i*4 +: 4] == 4'd0) r[i*4 +: 4] = 4'hF;
            else lead = 1'b0;
        end
`endif
        return r;
    endfunction

    task automatic run_conv(input logic [15:0] v, input logic [19:0] exp,
                            input int inj_a, input int inj_b, input string name);
        int          nbusy;
        int          ndone;
        int          done_at;
        int          flicker;
        logic [19:0] got;
        logic [19:0] prev;
        @(negedge clock);
        chk({name, "_ready_before"}, 32'(ready), 32'd1);
        prev  = digits;
        valor = v;
        load  = 1'b1;
        @(negedge clock);
        load    = 1'b0;
        valor   = 16'd999;
        nbusy   = 0;
        ndone   = 0;
        done_at = -1;
        flicker = 0;
        got     = '0;
        for (int c = 1; c <= 40; c++) begin
            if (ready) break;
            if (busy) nbusy++;
            if (done) begin
                ndone++;
                done_at = c;
                got     = digits;
            end else if (ndone == 0 && digits !== prev) begin
                flicker++;
            end
            if (c == inj_a || c == inj_b) begin
                valor = 16'd999;
                load  = 1'b1;
            end else begin
                load = 1'b0;
            end
            @(negedge clock);
        end
        load = 1'b0;
        chk({name, "_ready_after"}, 32'(ready), 32'd1);
        chk({name, "_busy_cycles"}, 32'(nbusy), 32'd17);
        chk({name, "_done_count"}, 32'(ndone), 32'd1);
        chk({name, "_done_cycle"}, 32'(done_at), 32'd17);
        chk({name, "_held"}, 32'(flicker), 32'd0);
        chk({name, "_digits_at_done"}, 32'(got), 32'(exp));
        chk({name, "_digits"}, 32'(digits), 32'(exp));
        @(negedge clock);
        chk({name, "_stays_idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [19:0] q[$];
        int          last_done;
        int          nd;

        vecs[0] = '{16'd1234,  20'h01234, 20'hF1234, 0, 0};
        vecs[1] = '{16'd65535, 20'h65535, 20'h65535, 0, 0};
        vecs[2] = '{16'd0,     20'h00000, 20'hFFFF0, 0, 0};
        vecs[3] = '{16'd42,    20'h00042, 20'hFFF42, 3, 17};
        vecs[4] = '{16'd9999,  20'h09999, 20'hF9999, 0, 0};
        vecs[5] = '{16'd10000, 20'h10000, 20'h10000, 0, 0};
        vecs[6] = '{16'd100,   20'h00100, 20'hFF100, 0, 0};
        vecs[7] = '{16'd500,   20'h00500, 20'hFF500, 0, 0};

        reset_n = 1'b0;
        load    = 1'b0;
        valor   = '0;
        repeat (3) @(negedge clock);
        chk("reset_digits", 32'(digits), 32'h0);
        chk("reset_ready",  32'(ready),  32'd1);
        chk("reset_busy",   32'(busy),   32'd0);
        chk("reset_done",   32'(done),   32'd0);
        reset_n = 1'b1;
        @(negedge clock);
        chk("post_reset_ready", 32'(ready), 32'd1);

        for (int i = 0; i < 8; i++) begin
            run_conv(vecs[i].val, expect_of(vecs[i]), vecs[i].inj_a, vecs[i].inj_b,
                     $sformatf("v%0d", vecs[i].val));
        end

        // Reset during the conversion of 7, digits currently show 500.
        @(negedge clock);
        valor = 16'd7;
        load  = 1'b1;
        @(negedge clock);
        load = 1'b0;
        repeat (7) @(negedge clock);
        chk("midconv_busy_before", 32'(busy), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        chk("midconv_rst_digits", 32'(digits), 32'h0);
        chk("midconv_rst_ready",  32'(ready),  32'd1);
        chk("midconv_rst_busy",   32'(busy),   32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        run_conv(16'd7, model(7), 0, 0, "fresh7");

        // Asynchronous reset from idle, between clock edges.
        @(negedge clock);
        #2 reset_n = 1'b0;
        #1;
        chk("async_rst_digits", 32'(digits), 32'h0);
        chk("async_rst_ready",  32'(ready),  32'd1);
        chk("async_rst_done",   32'(done),   32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);

        // Back-to-back: load held high, valor incrementing every cycle.
        valor     = 16'd9990;
        load      = 1'b1;
        last_done = -1;
        nd        = 0;
        for (int c = 0; c < 75; c++) begin
            if (done) begin
                if (q.size() == 0) begin
                    chk("b2b_queue_empty", 32'd0, 32'd1);
                end else begin
                    chk($sformatf("b2b_digits_%0d", nd), 32'(digits), 32'(q.pop_front()));
                end
                if (last_done >= 0) chk($sformatf("b2b_interval_%0d", nd), 32'(c - last_done), 32'd18);
                last_done = c;
                nd++;
            end
            valor = valor + 16'd1;
            if (ready) q.push_back(model(int'(valor)));
            @(negedge clock);
        end
        load = 1'b0;
        chk("b2b_done_count", 32'(nd), 32'd4);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
